mem_stage_ctrl: RTL and testbench

Memory-stage controller with an integrated MEM/WB pipeline register. It sits directly downstream of the EX/MEM buffer and consumes that buffer's outputs. It drives the data memory, owns the stack pointer (SP), and sequences two-word PC push/pop for CALL/INT and RET/RTI. It stalls upstream stages during multi-cycle stack operations and presents a registered writeback bundle to the WB stage.

---
 rtl/mem_stage_ctrl_pkg.sv | 26 ++
 rtl/mem_stage_ctrl_if.sv | 39 +++
 rtl/mem_stage_ctrl_sp_unit.sv | 55 +++++
 rtl/mem_stage_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl_pkg
//  Description : Shared types and constants for the memory-stage controller.
//                Holds the FSM state encoding, the default data-memory
//                address width and the stack-top derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_ctrl_pkg;

    // Default data-memory word-address width (16-bit words).
    localparam int c_ADDR_W_DFLT = 11;

    // Two-word PC push/pop sequencer state, explicitly encoded.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PC2  = 1'b1
    } state_t;

    // The stack starts at the highest word address and grows downward.
    function automatic int stack_top_f(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl_if
//  Description : Data-memory bus between the memory-stage controller and
//                the data memory. Read data is combinational from the
//                address; writes commit on the clock edge when dmem_we is set.
//  Ports       : dmem_addr  - word address
//                dmem_wdata - write data
//                dmem_we    - write enable
//                dmem_rdata - read data returned by memory
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if #(
    parameter int ADDR_W = 11
) ();

    logic [ADDR_W-1:0] dmem_addr;
    logic [15:0]       dmem_wdata;
    logic              dmem_we;
    logic [15:0]       dmem_rdata;

    // Controller side drives address/data/enable and consumes read data.
    modport master (
        output dmem_addr,
        output dmem_wdata,
        output dmem_we,
        input  dmem_rdata
    );

    // Memory side.
    modport slave (
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_we,
        output dmem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl_sp_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl_sp_unit
//  Description : Stack-pointer register. Decrements on a push word,
//                increments on a pop word, wraps modulo 2**ADDR_W, and
//                raises a sticky fault on push at SP==0 or pop at
//                SP==STACK_TOP. The fault clears only on reset.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                i_sp_dec     - push word this cycle
//                i_sp_inc     - pop word this cycle
//                o_sp         - current SP
//                o_sp_plus1   - SP+1 (pop address)
//                o_sp_fault   - sticky overflow/underflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl_sp_unit #(
    parameter int ADDR_W    = 11,
    parameter int STACK_TOP = 2047
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_sp_dec,
    input  wire logic              i_sp_inc,
    output logic      [ADDR_W-1:0] o_sp,
    output logic      [ADDR_W-1:0] o_sp_plus1,
    output logic                   o_sp_fault
);

    localparam logic [ADDR_W-1:0] c_TOP  = ADDR_W'(STACK_TOP);
    localparam logic [ADDR_W-1:0] c_ZERO = '0;
    localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] r_sp;
    logic              r_fault;

    // Decrement wins if both are requested; the controller never asks for both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp    <= c_TOP;
            r_fault <= 1'b0;
        end else if (i_sp_dec) begin
            r_sp <= r_sp - c_ONE;
            if (r_sp == c_ZERO) r_fault <= 1'b1;
        end else if (i_sp_inc) begin
            r_sp <= r_sp + c_ONE;
            if (r_sp == c_TOP) r_fault <= 1'b1;
        end
    end

    assign o_sp       = r_sp;
    assign o_sp_plus1 = r_sp + c_ONE;
    assign o_sp_fault = r_fault;

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl
//  Description : Memory-stage controller with integrated MEM/WB register.
//                Drives data memory, owns the stack pointer, sequences
//                two-word PC push (CALL/INT) and pop (RET/RTI), stalls the
//                upstream stages for the first word and presents a
//                registered writeback bundle.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                mem_*_in               - EX/MEM buffer outputs
//                dmem                   - data-memory bus (master side)
//                mem_stall              - upstream freeze (combinational)
//                wb_*                   - registered writeback bundle
//                pc_restore(_valid)     - popped return PC, one-cycle pulse
//                sp_out, sp_fault       - stack pointer and sticky fault
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W_DFLT,
    parameter int STACK_TOP = stack_top_f(ADDR_W)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [2:0]        mem_Rdst_in,
    input  wire logic [15:0]       mem_result_in,
    input  wire logic [15:0]       mem_read_data1_in,
    input  wire logic              mem_MEM_Write_in,
    input  wire logic              mem_MEM_Read_in,
    input  wire logic              mem_STACK_SIGNAL_in,
    input  wire logic              mem_DEC_SP_in,
    input  wire logic              mem_INC_SP_in,
    input  wire logic              mem_MEM_to_REG_in,
    input  wire logic              mem_REG_Write_in,
    input  wire logic              mem_WRITE_PORT_in,
    input  wire logic              mem_PUSH_PC_in,
    input  wire logic              mem_POP_PC_in,
    input  wire logic [31:0]       mem_PC_in,
    mem_stage_ctrl_if.master       dmem,
    output logic                   mem_stall,
    output logic      [2:0]        wb_Rdst,
    output logic      [15:0]       wb_data,
    output logic                   wb_REG_Write,
    output logic                   wb_WRITE_PORT,
    output logic      [31:0]       pc_restore,
    output logic                   pc_restore_valid,
    output logic      [ADDR_W-1:0] sp_out,
    output logic                   sp_fault
);

    state_t            r_state;
    logic [15:0]       r_pc_lo;
    logic [31:0]       r_pc_restore;
    logic              r_pc_restore_valid;
    logic [2:0]        r_wb_rdst;
    logic [15:0]       r_wb_data;
    logic              r_wb_reg_write;
    logic              r_wb_write_port;

    logic [ADDR_W-1:0] w_sp;
    logic [ADDR_W-1:0] w_sp_plus1;
    logic              w_sp_fault;

    logic              w_push_pc;
    logic              w_pop_pc;
    logic              w_push;
    logic              w_pop;

    state_t            w_next_state;
    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       w_wdata;
    logic              w_we;
    logic              w_sp_dec;
    logic              w_sp_inc;
    logic              w_stall;
    logic              w_use_rdata;
    logic              w_latch_pc_lo;
    logic              w_restore_pc;

    // Operation decode. PUSH_PC outranks POP_PC; both outrank single-word
    // stack operations, which in turn outrank a plain access.
    assign w_push_pc = mem_PUSH_PC_in;
    assign w_pop_pc  = mem_POP_PC_in & ~mem_PUSH_PC_in;
    assign w_push    = mem_STACK_SIGNAL_in & mem_DEC_SP_in & mem_MEM_Write_in;
    assign w_pop     = mem_STACK_SIGNAL_in & mem_INC_SP_in & mem_MEM_Read_in;

    always_comb begin
        w_next_state  = IDLE;
        w_addr        = mem_result_in[ADDR_W-1:0];
        w_wdata       = mem_read_data1_in;
        w_we          = mem_MEM_Write_in;
        w_sp_dec      = 1'b0;
        w_sp_inc      = 1'b0;
        w_stall       = 1'b0;
        // Read-and-write on a plain access writes back the ALU result.
        w_use_rdata   = mem_MEM_to_REG_in & ~(mem_MEM_Read_in & mem_MEM_Write_in);
        w_latch_pc_lo = 1'b0;
        w_restore_pc  = 1'b0;

        if (r_state == IDLE) begin
            if (w_push_pc) begin
                w_addr       = w_sp;
                w_wdata      = mem_PC_in[31:16];
                w_we         = 1'b1;
                w_sp_dec     = 1'b1;
                w_stall      = 1'b1;
                w_next_state = PC2;
            end else if (w_pop_pc) begin
                w_addr        = w_sp_plus1;
                w_we          = 1'b0;
                w_sp_inc      = 1'b1;
                w_stall       = 1'b1;
                w_latch_pc_lo = 1'b1;
                w_next_state  = PC2;
            end else if (w_push) begin
                w_addr   = w_sp;
                w_we     = 1'b1;
                w_sp_dec = 1'b1;
            end else if (w_pop) begin
                w_addr      = w_sp_plus1;
                w_we        = 1'b0;
                w_sp_inc    = 1'b1;
                w_use_rdata = 1'b1;
            end
        end else begin
            // Second word: inputs are held from the first cycle.
            if (w_push_pc) begin
                w_addr   = w_sp;
                w_wdata  = mem_PC_in[15:0];
                w_we     = 1'b1;
                w_sp_dec = 1'b1;
            end else if (w_pop_pc) begin
                w_addr       = w_sp_plus1;
                w_we         = 1'b0;
                w_sp_inc     = 1'b1;
                w_restore_pc = 1'b1;
            end else begin
                w_we = 1'b0;
            end
        end
    end

    mem_stage_ctrl_sp_unit #(
        .ADDR_W    (ADDR_W),
        .STACK_TOP (STACK_TOP)
    ) u_sp_unit (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sp_dec   (w_sp_dec),
        .i_sp_inc   (w_sp_inc),
        .o_sp       (w_sp),
        .o_sp_plus1 (w_sp_plus1),
        .o_sp_fault (w_sp_fault)
    );

    // Sequencer state, MEM/WB register and PC-restore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= IDLE;
            r_pc_lo            <= '0;
            r_pc_restore       <= '0;
            r_pc_restore_valid <= 1'b0;
            r_wb_rdst          <= '0;
            r_wb_data          <= '0;
            r_wb_reg_write     <= 1'b0;
            r_wb_write_port    <= 1'b0;
        end else begin
            r_state            <= w_next_state;
            r_pc_restore_valid <= w_restore_pc;
            if (w_latch_pc_lo) r_pc_lo <= dmem.dmem_rdata;
            if (w_restore_pc)  r_pc_restore <= {dmem.dmem_rdata, r_pc_lo};
            r_wb_rdst          <= mem_Rdst_in;
            r_wb_data          <= w_use_rdata ? dmem.dmem_rdata : mem_result_in;
            // The stall cycle is not a real instruction completion: bubble it.
            r_wb_reg_write     <= mem_REG_Write_in  & ~w_stall;
            r_wb_write_port    <= mem_WRITE_PORT_in & ~w_stall;
        end
    end

    // Reset forces the combinational controls quiet so an aborted sequence
    // cannot issue a further write or hold the pipeline frozen.
    assign dmem.dmem_addr  = w_addr;
    assign dmem.dmem_wdata = w_wdata;
    assign dmem.dmem_we    = w_we & rst_n;
    assign mem_stall       = w_stall & rst_n;

    assign wb_Rdst          = r_wb_rdst;
    assign wb_data          = r_wb_data;
    assign wb_REG_Write     = r_wb_reg_write;
    assign wb_WRITE_PORT    = r_wb_write_port;
    assign pc_restore       = r_pc_restore;
    assign pc_restore_valid = r_pc_restore_valid;
    assign sp_out           = w_sp;
    assign sp_fault         = w_sp_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_ctrl
//  Description : Directed self-checking bench for mem_stage_ctrl with a
//                behavioural 2K x 16 data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int c_AW = 11;

    logic            clk;
    logic            rst_n;
    logic [2:0]      rdst;
    logic [15:0]     result;
    logic [15:0]     rd1;
    logic            mem_write;
    logic            mem_read;
    logic            stack_sig;
    logic            dec_sp;
    logic            inc_sp;
    logic            mem_to_reg;
    logic            reg_write;
    logic            write_port;
    logic            push_pc;
    logic            pop_pc;
    logic [31:0]     pc;

    logic            mem_stall;
    logic [2:0]      wb_Rdst;
    logic [15:0]     wb_data;
    logic            wb_REG_Write;
    logic            wb_WRITE_PORT;
    logic [31:0]     pc_restore;
    logic            pc_restore_valid;
    logic [c_AW-1:0] sp_out;
    logic            sp_fault;

    logic [15:0]     r_mem [0:2047];

    int              n_cmp;
    int              n_err;

    mem_stage_ctrl_if #(.ADDR_W(c_AW)) dmem_bus ();

    mem_stage_ctrl #(.ADDR_W(c_AW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mem_Rdst_in         (rdst),
        .mem_result_in       (result),
        .mem_read_data1_in   (rd1),
        .mem_MEM_Write_in    (mem_write),
        .mem_MEM_Read_in     (mem_read),
        .mem_STACK_SIGNAL_in (stack_sig),
        .mem_DEC_SP_in       (dec_sp),
        .mem_INC_SP_in       (inc_sp),
        .mem_MEM_to_REG_in   (mem_to_reg),
        .mem_REG_Write_in    (reg_write),
        .mem_WRITE_PORT_in   (write_port),
        .mem_PUSH_PC_in      (push_pc),
        .mem_POP_PC_in       (pop_pc),
        .mem_PC_in           (pc),
        .dmem                (dmem_bus),
        .mem_stall           (mem_stall),
        .wb_Rdst             (wb_Rdst),
        .wb_data             (wb_data),
        .wb_REG_Write        (wb_REG_Write),
        .wb_WRITE_PORT       (wb_WRITE_PORT),
        .pc_restore          (pc_restore),
        .pc_restore_valid    (pc_restore_valid),
        .sp_out              (sp_out),
        .sp_fault            (sp_fault)
    );

    // Behavioural data memory: combinational read, synchronous write.
    assign dmem_bus.dmem_rdata = r_mem[dmem_bus.dmem_addr];
    always @(posedge clk) begin
        if (dmem_bus.dmem_we) r_mem[dmem_bus.dmem_addr] <= dmem_bus.dmem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        rdst = 3'd0; result = 16'h0; rd1 = 16'h0;
        mem_write = 1'b0; mem_read = 1'b0; stack_sig = 1'b0;
        dec_sp = 1'b0; inc_sp = 1'b0; mem_to_reg = 1'b0;
        reg_write = 1'b0; write_port = 1'b0;
        push_pc = 1'b0; pop_pc = 1'b0; pc = 32'h0;
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [15:0] d);
        clear_in();
        stack_sig = 1'b1; dec_sp = 1'b1; mem_write = 1'b1; rd1 = d;
    endtask

    task automatic set_pop(input logic [2:0] rd);
        clear_in();
        stack_sig = 1'b1; inc_sp = 1'b1; mem_read = 1'b1;
        rdst = rd; reg_write = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_in();
        rst_n = 1'b0;
        // Request a PC push while reset is held: nothing may stall or write.
        push_pc = 1'b1; pc = 32'hDEAD_BEEF;
        #1;
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_we", {31'd0, dmem_bus.dmem_we}, 32'd0);
        tick(); tick();
        chk("rst_sp", {21'd0, sp_out}, 32'h7FF);
        chk("rst_wb_data", {16'd0, wb_data}, 32'h0);
        chk("rst_wb_regw", {31'd0, wb_REG_Write}, 32'd0);
        chk("rst_pcr_valid", {31'd0, pc_restore_valid}, 32'd0);
        chk("rst_pcr", pc_restore, 32'h0);
        chk("rst_fault", {31'd0, sp_fault}, 32'd0);
        clear_in();
        rst_n = 1'b1;
        tick();

        // Single-word PUSH then POP.
        set_push(16'hBEEF);
        #1;
        chk("push_addr", {21'd0, dmem_bus.dmem_addr}, 32'h7FF);
        chk("push_we", {31'd0, dmem_bus.dmem_we}, 32'd1);
        chk("push_wdata", {16'd0, dmem_bus.dmem_wdata}, 32'hBEEF);
        tick();
        chk("push_sp", {21'd0, sp_out}, 32'h7FE);
        set_pop(3'd3);
        #1;
        chk("pop_addr", {21'd0, dmem_bus.dmem_addr}, 32'h7FF);
        chk("pop_we", {31'd0, dmem_bus.dmem_we}, 32'd0);
        tick();
        chk("pop_wb_data", {16'd0, wb_data}, 32'hBEEF);
        chk("pop_wb_rdst", {29'd0, wb_Rdst}, 32'd3);
        chk("pop_wb_regw", {31'd0, wb_REG_Write}, 32'd1);
        chk("pop_sp", {21'd0, sp_out}, 32'h7FF);

        // PUSH_PC of 0x0001_2345; REG_Write high must be bubbled in the stall cycle.
        clear_in();
        push_pc = 1'b1; pc = 32'h0001_2345; reg_write = 1'b1; write_port = 1'b1;
        #1;
        chk("ppc0_addr", {21'd0, dmem_bus.dmem_addr}, 32'h7FF);
        chk("ppc0_wdata", {16'd0, dmem_bus.dmem_wdata}, 32'h0001);
        chk("ppc0_stall", {31'd0, mem_stall}, 32'd1);
        tick();
        chk("ppc0_bubble_regw", {31'd0, wb_REG_Write}, 32'd0);
        chk("ppc0_bubble_wport", {31'd0, wb_WRITE_PORT}, 32'd0);
        chk("ppc0_sp", {21'd0, sp_out}, 32'h7FE);
        #1;
        chk("ppc1_addr", {21'd0, dmem_bus.dmem_addr}, 32'h7FE);
        chk("ppc1_wdata", {16'd0, dmem_bus.dmem_wdata}, 32'h2345);
        chk("ppc1_stall", {31'd0, mem_stall}, 32'd0);
        chk("ppc1_we", {31'd0, dmem_bus.dmem_we}, 32'd1);
        tick();
        chk("ppc1_sp", {21'd0, sp_out}, 32'h7FD);
        chk("ppc1_regw", {31'd0, wb_REG_Write}, 32'd1);
        chk("ppc_mem_hi", {16'd0, r_mem[11'h7FF]}, 32'h0001);
        chk("ppc_mem_lo", {16'd0, r_mem[11'h7FE]}, 32'h2345);

        // POP_PC restores 0x0001_2345.
        clear_in();
        pop_pc = 1'b1;
        #1;
        chk("opc0_addr", {21'd0, dmem_bus.dmem_addr}, 32'h7FE);
        chk("opc0_stall", {31'd0, mem_stall}, 32'd1);
        chk("opc0_we", {31'd0, dmem_bus.dmem_we}, 32'd0);
        tick();
        chk("opc0_valid", {31'd0, pc_restore_valid}, 32'd0);
        #1;
        chk("opc1_addr", {21'd0, dmem_bus.dmem_addr}, 32'h7FF);
        chk("opc1_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("opc_pcr", pc_restore, 32'h0001_2345);
        chk("opc_valid", {31'd0, pc_restore_valid}, 32'd1);
        chk("opc_sp", {21'd0, sp_out}, 32'h7FF);
        clear_in();
        tick();
        chk("opc_valid_pulse", {31'd0, pc_restore_valid}, 32'd0);

        // Plain store, upper result bits ignored for the address.
        clear_in();
        mem_write = 1'b1; result = 16'hF810; rd1 = 16'h1234;
        #1;
        chk("st_addr", {21'd0, dmem_bus.dmem_addr}, 32'h010);
        chk("st_we", {31'd0, dmem_bus.dmem_we}, 32'd1);
        tick();
        chk("st_sp", {21'd0, sp_out}, 32'h7FF);
        // Plain load.
        clear_in();
        mem_read = 1'b1; mem_to_reg = 1'b1; result = 16'h0010;
        rdst = 3'd5; reg_write = 1'b1;
        tick();
        chk("ld_wb_data", {16'd0, wb_data}, 32'h1234);
        chk("ld_wb_rdst", {29'd0, wb_Rdst}, 32'd5);
        // Plain ALU writeback without memory.
        clear_in();
        result = 16'h5A5A; write_port = 1'b1;
        tick();
        chk("alu_wb_data", {16'd0, wb_data}, 32'h5A5A);
        chk("alu_wb_wport", {31'd0, wb_WRITE_PORT}, 32'd1);
        // Read and write together: write happens, result is written back.
        clear_in();
        mem_read = 1'b1; mem_write = 1'b1; mem_to_reg = 1'b1;
        result = 16'h0020; rd1 = 16'hAAAA;
        #1;
        chk("rw_we", {31'd0, dmem_bus.dmem_we}, 32'd1);
        tick();
        chk("rw_wb_data", {16'd0, wb_data}, 32'h0020);
        chk("rw_mem", {16'd0, r_mem[11'h020]}, 32'hAAAA);

        // PUSH_PC and POP_PC together: push wins.
        clear_in();
        push_pc = 1'b1; pop_pc = 1'b1; pc = 32'hCAFE_F00D; reg_write = 1'b1;
        #1;
        chk("both0_wdata", {16'd0, dmem_bus.dmem_wdata}, 32'hCAFE);
        chk("both0_we", {31'd0, dmem_bus.dmem_we}, 32'd1);
        chk("both0_stall", {31'd0, mem_stall}, 32'd1);
        tick();
        chk("both0_bubble", {31'd0, wb_REG_Write}, 32'd0);
        #1;
        chk("both1_wdata", {16'd0, dmem_bus.dmem_wdata}, 32'hF00D);
        tick();
        chk("both_sp", {21'd0, sp_out}, 32'h7FD);
        chk("both_no_restore", {31'd0, pc_restore_valid}, 32'd0);
        clear_in();
        pop_pc = 1'b1;
        tick(); tick();
        chk("both_pop_pcr", pc_restore, 32'hCAFE_F00D);
        chk("both_pop_sp", {21'd0, sp_out}, 32'h7FF);

        // POP at the stack top wraps SP and sets the sticky fault.
        set_pop(3'd1);
        #1;
        chk("uf_addr", {21'd0, dmem_bus.dmem_addr}, 32'h000);
        tick();
        chk("uf_sp", {21'd0, sp_out}, 32'h000);
        chk("uf_fault", {31'd0, sp_fault}, 32'd1);
        clear_in();
        tick(); tick(); tick();
        chk("uf_fault_sticky", {31'd0, sp_fault}, 32'd1);
        // PUSH at SP==0 wraps back to the top.
        set_push(16'h5555);
        #1;
        chk("of_addr", {21'd0, dmem_bus.dmem_addr}, 32'h000);
        tick();
        chk("of_sp", {21'd0, sp_out}, 32'h7FF);
        chk("of_fault", {31'd0, sp_fault}, 32'd1);

        // Reset asserted in the second cycle of a PC push aborts it.
        clear_in();
        push_pc = 1'b1; pc = 32'h1111_2222;
        tick();
        #1;
        chk("abort_pre_we", {31'd0, dmem_bus.dmem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_stall", {31'd0, mem_stall}, 32'd0);
        chk("abort_we", {31'd0, dmem_bus.dmem_we}, 32'd0);
        chk("abort_sp", {21'd0, sp_out}, 32'h7FF);
        chk("abort_fault", {31'd0, sp_fault}, 32'd0);
        tick();
        chk("abort_mem_hi", {16'd0, r_mem[11'h7FF]}, 32'h1111);
        chk("abort_mem_lo", {16'd0, r_mem[11'h7FE]}, 32'hF00D);
        rst_n = 1'b1;
        // After the abort the controller is back in IDLE: a single PUSH works.
        set_push(16'h7777);
        #1;
        chk("post_addr", {21'd0, dmem_bus.dmem_addr}, 32'h7FF);
        chk("post_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("post_sp", {21'd0, sp_out}, 32'h7FE);
        chk("post_mem", {16'd0, r_mem[11'h7FF]}, 32'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
